line_memory: RTL and testbench

- Downstream backing store for the cache; slave end of its next-level port.
- Serves whole-line fills (reads) and writebacks (writes) as fixed-length bursts of LINEWORDS words.
- Applies a programmable access latency, so the cache's miss and writeback paths see realistic timing.
- Behavioural RAM with a request/ack/burst handshake; simulation target, synthesizable subset only.

---
 rtl/line_memory.sv | 160 ++++++++++++++++
 tb/tb_line_memory.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_memory.sv
// line_memory: behavioural next-level RAM for the cache, serving whole-line fills and
// writebacks as fixed-length bursts behind a programmable access latency.
// Optional feature macro: LINE_MEMORY_CWF_EN (critical-word-first burst order).
module line_memory #(
  parameter int unsigned ADDRBITS  = 32,
  parameter int unsigned WORDBITS  = 32,
  parameter int unsigned LINEWORDS = 16,
  parameter int unsigned MEMDEPTH  = 4096,
  parameter int unsigned LATENCY   = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req,
  input  logic                we,
  input  logic [ADDRBITS-1:0] addr,
  input  logic [WORDBITS-1:0] wdata,
  input  logic                wvalid,
  output logic                ack,
  output logic                busy,
  output logic                rvalid,
  output logic [WORDBITS-1:0] rdata,
  output logic                done
);

  localparam int unsigned IW   = $clog2(MEMDEPTH);
  localparam int unsigned BW   = $clog2(LINEWORDS);
  localparam int unsigned LATW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_RWAIT  = 3'd2;
  localparam logic [2:0] S_RBURST = 3'd3;
  localparam logic [2:0] S_WBURST = 3'd4;
  localparam logic [2:0] S_WWAIT  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [WORDBITS-1:0] mem [MEMDEPTH];

  logic [2:0]      state_q, state_d;
  logic            we_q, we_d;
  logic [IW-1:0]   base_q, base_d;
  logic [BW-1:0]   off_q, off_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [LATW-1:0] lat_q, lat_d;

  logic                ack_q, busy_q, rvalid_q, done_q;
  logic [WORDBITS-1:0] rdata_q;

  logic          mem_we_c;
  logic [IW-1:0] idx_c;
  logic [IW-1:0] cur_addr_c;
  logic [IW-1:0] rd_addr_c;

  // Aliased word index and the beat addresses for the current and next cycle.
  assign idx_c      = IW'(addr % ADDRBITS'(MEMDEPTH));
  assign cur_addr_c = base_q | IW'(BW'(off_q + beat_q));
  assign rd_addr_c  = base_q | IW'(BW'(off_q + beat_d));

  // State and transaction registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      base_q  <= '0;
      off_q   <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      base_q  <= base_d;
      off_q   <= off_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
    end
  end

  // Next-state logic: latency countdown, beat sequencing and write strobes.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    base_d   = base_q;
    off_d    = off_q;
    beat_d   = beat_q;
    lat_d    = lat_q;
    mem_we_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_ACCEPT;
          we_d    = we;
          base_d  = idx_c & ~IW'(LINEWORDS - 1);
`ifdef LINE_MEMORY_CWF_EN
          off_d   = BW'(idx_c);
`else
          off_d   = '0;
`endif
          beat_d  = '0;
        end
      end
      S_ACCEPT: begin
        lat_d = LATW'(LATENCY);
        if (we_q)              state_d = S_WBURST;
        else if (LATENCY == 0) state_d = S_RBURST;
        else                   state_d = S_RWAIT;
      end
      S_RWAIT: begin
        lat_d = lat_q - LATW'(1);
        if (lat_q == LATW'(1)) state_d = S_RBURST;
      end
      S_RBURST: begin
        beat_d = beat_q + BW'(1);
        if (beat_q == BW'(LINEWORDS - 1)) state_d = S_DONE;
      end
      S_WBURST: begin
        if (wvalid) begin
          mem_we_c = 1'b1;
          beat_d   = beat_q + BW'(1);
          lat_d    = LATW'(LATENCY);
          if (beat_q == BW'(LINEWORDS - 1)) state_d = (LATENCY == 0) ? S_DONE : S_WWAIT;
        end
      end
      S_WWAIT: begin
        lat_d = lat_q - LATW'(1);
        if (lat_q == LATW'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs decoded from the next state; read data fetched one cycle ahead.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ack_q    <= (state_d == S_ACCEPT);
      busy_q   <= (state_d != S_IDLE);
      rvalid_q <= (state_d == S_RBURST);
      done_q   <= (state_d == S_DONE);
      rdata_q  <= (state_d == S_RBURST) ? mem[rd_addr_c] : '0;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_we_c) mem[cur_addr_c] <= wdata;
  end

  assign ack    = ack_q;
  assign busy   = busy_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign done   = done_q;

endmodule

// File: tb/tb_line_memory.sv
// tb_line_memory: checks line_memory (LATENCY=4 and LATENCY=0 instances) against a
// word-array model of the RAM with burst order computed from the line addressing rules.
module tb_line_memory;

`ifdef LINE_MEMORY_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic [1:0] req, we, wvalid, ack, busy, rvalid, done;
  logic [31:0] addr_v [2];
  logic [31:0] wdata_v [2];
  logic [31:0] rdata_v [2];

  logic [31:0] mdl [2][4096];
  logic [31:0] wlist0 [$];
  logic [31:0] wlist1 [$];

  int total = 0;
  int bad = 0;

  line_memory #(.LATENCY(4)) u_dut4 (
    .clock(clk), .reset(rst_n), .req(req[0]), .we(we[0]), .addr(addr_v[0]),
    .wdata(wdata_v[0]), .wvalid(wvalid[0]), .ack(ack[0]), .busy(busy[0]),
    .rvalid(rvalid[0]), .rdata(rdata_v[0]), .done(done[0])
  );

  line_memory #(.LATENCY(0)) u_dut0 (
    .clock(clk), .reset(rst_n), .req(req[1]), .we(we[1]), .addr(addr_v[1]),
    .wdata(wdata_v[1]), .wvalid(wvalid[1]), .ack(ack[1]), .busy(busy[1]),
    .rvalid(rvalid[1]), .rdata(rdata_v[1]), .done(done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] seed;
    int          stall;
    bit          spam;
    int          lat;
    bit          chk_first;
    logic [31:0] exp_first;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model address of beat k of the burst requested at a.
  function automatic int beat_addr(input logic [31:0] a, input int k);
    int idx, base, off;
    idx  = int'(a % 32'd4096);
    base = idx - (idx % 16);
    off  = CWF ? (idx % 16) : 0;
    return base + ((off + k) % 16);
  endfunction

  task automatic do_write(input int s, input logic [31:0] a, input int lat,
                          input logic [31:0] seed, input int stall);
    int k, cyc, dn, blo;
    bit v;
    req[s] = 1'b1; we[s] = 1'b1; addr_v[s] = a; wvalid[s] = 1'b0;
    tick();
    req[s] = 1'b0;
    check("wr_ack", 32'(ack[s]), 32'd1);
    // A beat offered during ACCEPT must be ignored.
    wvalid[s] = 1'b1; wdata_v[s] = 32'hDEAD_BEEF;
    k = 0; cyc = 0;
    while (k < 16) begin
      tick();
      case (stall)
        1:       v = ((cyc % 3) == 0);
        2:       v = ($urandom_range(0, 1) == 1);
        default: v = 1'b1;
      endcase
      if (v) begin
        wvalid[s] = 1'b1; wdata_v[s] = seed + 32'(k);
        mdl[s][beat_addr(a, k)] = seed + 32'(k);
        k++;
      end else begin
        wvalid[s] = 1'b0; wdata_v[s] = $urandom();
      end
      cyc++;
    end
    dn = -1; blo = 0;
    for (int c = 1; c <= 20 && dn < 0; c++) begin
      tick();
      if (c == 1) wvalid[s] = 1'b0;
      if (!busy[s]) blo++;
      if (done[s]) dn = c;
    end
    check("wr_done_delay", 32'(dn), 32'(lat + 1));
    check("wr_busy_held", 32'(blo), 32'd0);
    tick();
    check("wr_idle_busy", 32'(busy[s]), 32'd0);
    if (s == 0) wlist0.push_back(a); else wlist1.push_back(a);
  endtask

  task automatic do_read(input int s, input logic [31:0] a, input int lat, input bit spam,
                         output logic [31:0] first_word);
    int acks, blo, first_rv, beat, done_n, nz;
    logic [31:0] exp;
    req[s] = 1'b1; we[s] = 1'b0; addr_v[s] = a; wvalid[s] = 1'b0;
    acks = 0; blo = 0; first_rv = -1; beat = 0; done_n = -1; nz = 0;
    first_word = 32'hFFFF_FFFF;
    for (int n = 1; n <= 60 && done_n < 0; n++) begin
      tick();
      if (n == 1 && !spam) req[s] = 1'b0;
      if (ack[s]) acks++;
      if (!busy[s]) blo++;
      if (rvalid[s]) begin
        if (first_rv < 0) first_rv = n;
        if (beat < 16) begin
          exp = mdl[s][beat_addr(a, beat)];
          check($sformatf("rd_beat%0d", beat), rdata_v[s], exp);
        end
        if (beat == 0) first_word = rdata_v[s];
        beat++;
      end else if (rdata_v[s] != 32'd0) begin
        nz++;
      end
      if (done[s]) done_n = n;
    end
    req[s] = 1'b0;
    check("rd_ack_count", 32'(acks), 32'd1);
    check("rd_first_rvalid", 32'(first_rv), 32'(lat + 2));
    check("rd_beat_count", 32'(beat), 32'd16);
    check("rd_done_cycle", 32'(done_n), 32'(lat + 18));
    check("rd_busy_held", 32'(blo), 32'd0);
    check("rd_rdata_idle_zero", 32'(nz), 32'd0);
    tick();
    check("rd_idle_busy", 32'(busy[s]), 32'd0);
  endtask

  initial begin
    logic [31:0] fw, r, a, line;
    int s, lat;

    rst_n = 1'b0;
    req = '0; we = '0; wvalid = '0;
    for (int i = 0; i < 2; i++) begin addr_v[i] = '0; wdata_v[i] = '0; end

    vecs[0] = '{0, 1'b1, 32'h40,   32'hA0, 0, 1'b0, 4, 1'b0, 32'h0};
    vecs[1] = '{0, 1'b0, 32'h40,   32'h0,  0, 1'b0, 4, 1'b1, 32'hA0};
    vecs[2] = '{0, 1'b1, 32'h80,   32'hB0, 1, 1'b0, 4, 1'b0, 32'h0};
    vecs[3] = '{0, 1'b0, 32'h80,   32'h0,  0, 1'b0, 4, 1'b1, 32'hB0};
    vecs[4] = '{0, 1'b0, 32'h1040, 32'h0,  0, 1'b1, 4, 1'b1, 32'hA0};
    vecs[5] = '{0, 1'b0, 32'h4B,   32'h0,  0, 1'b0, 4, 1'b1, CWF ? 32'hAB : 32'hA0};
    vecs[6] = '{1, 1'b1, 32'h40,   32'hA0, 0, 1'b0, 0, 1'b0, 32'h0};
    vecs[7] = '{1, 1'b0, 32'h40,   32'h0,  0, 1'b1, 0, 1'b1, 32'hA0};
    vecs[8] = '{1, 1'b1, 32'h7C3,  32'hC0, 2, 1'b0, 0, 1'b0, 32'h0};
    vecs[9] = '{1, 1'b0, 32'h7C0,  32'h0,  0, 1'b0, 0, 1'b1, CWF ? 32'hCD : 32'hC0};

    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      check("rst_ack",    32'(ack[i]),    32'd0);
      check("rst_busy",   32'(busy[i]),   32'd0);
      check("rst_rvalid", 32'(rvalid[i]), 32'd0);
      check("rst_done",   32'(done[i]),   32'd0);
      check("rst_rdata",  rdata_v[i],     32'd0);
    end
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].sel, vecs[i].addr, vecs[i].lat, vecs[i].seed, vecs[i].stall);
      end else begin
        do_read(vecs[i].sel, vecs[i].addr, vecs[i].lat, vecs[i].spam, fw);
        if (vecs[i].chk_first) check($sformatf("vec%0d_first_word", i), fw, vecs[i].exp_first);
      end
    end

    // Reset asserted during beat 5 of a fill on the LATENCY=4 instance.
    req[0] = 1'b1; we[0] = 1'b0; addr_v[0] = 32'h40;
    tick();
    req[0] = 1'b0;
    repeat (10) tick();
    check("pre_rst_rvalid", 32'(rvalid[0]), 32'd1);
    check("pre_rst_beat5", rdata_v[0], mdl[0][beat_addr(32'h40, 5)]);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {27'd0, ack[0], busy[0], rvalid[0], done[0], 1'b0}, 32'd0);
    check("midrst_rdata", rdata_v[0], 32'd0);
    tick();
    check("midrst_no_done", 32'(done[0]), 32'd0);
    rst_n = 1'b1;
    tick();
    check("postrst_idle", 32'(busy[0]), 32'd0);
    do_read(0, 32'h40, 4, 1'b0, fw);
    check("postrst_first_word", fw, CWF ? 32'hA0 : 32'hA0);

    // Random traffic: writes to random lines, reads of previously written lines via aliases.
    for (int it = 0; it < 12; it++) begin
      s = $urandom_range(0, 1);
      lat = (s == 0) ? 4 : 0;
      if ($urandom_range(0, 1) == 1 || (s == 0 ? wlist0.size() : wlist1.size()) == 0) begin
        do_write(s, $urandom(), lat, $urandom(), $urandom_range(0, 2));
      end else begin
        line = (s == 0) ? wlist0[$urandom_range(0, wlist0.size() - 1)]
                        : wlist1[$urandom_range(0, wlist1.size() - 1)];
        r = $urandom();
        a = (r & 32'hFFFF_F00F) | (line & 32'h0000_0FF0);
        do_read(s, a, lat, 1'($urandom_range(0, 1)), fw);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
